mem_datos_param: RTL
====================

// Module: mem_datos_param
// PURPOSE
//  Parametrised data memory for the datapath MEM stage; successor to the fixed 128x32 word memory.
//  Byte-addressed, with byte/half/word loads and stores, sign or zero extension on loads,
//  and a valid/ready request port.
//  Pipelined read latency of 1..4 cycles; clears its own contents after reset with an init FSM.
// PARAMETERS
//  DEPTH   128                 number of 32-bit words (power of 2, >=4)
//  ADDR_W  $clog2(DEPTH)+2     byte-address width (derived; do not override)
//  RD_LAT  1                   read latency in cycles, from accept to rsp_valid (1..4)
// PORTS
//  reloj         in   1       clock, rising edge
//  reset_n       in   1       asynchronous reset, active low
//  req_valid     in   1       request present
//  req_ready     out  1       block can accept a request this cycle
//  req_we        in   1       1=store, 0=load
//  req_size      in   2       00 byte, 01 half, 10 word, 11 reserved (treated as word)
//  req_unsigned  in   1       load: 1 zero-extend, 0 sign-extend
//  req_addr      in   ADDR_W  byte address; word index = req_addr[ADDR_W-1:2]
//  req_wdata     in   32      store data, right-justified (byte in [7:0], half in [15:0])
//  rsp_valid     out  1       one-cycle pulse: load data valid
//  rsp_rdata     out  32      extended load data; holds its value between responses
//  err           out  1       misaligned-access pulse (MEM_ALIGN_CHK_EN only, else tied 0)
// BEHAVIOUR
//  Reset (reset_n=0, async):
//   - state=INIT, init index=0; req_ready=0, rsp_valid=0, rsp_rdata=0, err=0.
//   - Read pipeline flushed; in-flight loads are lost and produce no response.
//  FSM:
//   - INIT: writes 0 to word[idx], one word per cycle, idx 0..DEPTH-1.
//     req_ready=0 and req_valid is ignored.
//     After word DEPTH-1 is written -> RUN.
//     First req_ready=1 occurs on the cycle after DEPTH init writes.
//   - RUN: req_ready=1 permanently; leaves only on reset.
//  Accept: req_valid & req_ready at a rising edge. Single port, one op per cycle, back-to-back allowed.
//  Store:
//   - Only the selected lanes update at the accepting edge; other bytes keep their value.
//   - Little-endian lanes: byte -> lane addr[1:0]; half -> lanes {addr[1],1},{addr[1],0}; word -> all lanes.
//   - No response for stores (rsp_valid stays 0).
//  Load:
//   - Word read at the accepting edge; lane selection and extension are applied in the pipeline.
//   - rsp_valid=1 exactly RD_LAT cycles after accept; one response per load, in order.
//   - Extension: byte/half sign-extended unless req_unsigned=1; word is passed unchanged.
//  Hazards:
//   - Load accepted the cycle after a store to the same word returns the new data.
//   - Read-before-write ordering is not a concern: one op per cycle.
//  Alignment (without macro): low bits ignored; half uses addr[1] only, word ignores addr[1:0].
// CONFIGURATION
//  MEM_ALIGN_CHK_EN defined:
//   - Misaligned accesses are half with addr[0]=1, and word/reserved with addr[1:0]!=0.
//   - Misaligned store: memory unchanged; err=1 for one cycle, the cycle after accept.
//   - Misaligned load: rsp_valid as normal with rsp_rdata=0; err=1 in the same cycle as rsp_valid.
//  MEM_ALIGN_CHK_EN undefined: no check logic; err tied to 0; alignment handled as above.
// TESTING
//  1. Reset, release:
//     -> req_ready=0 for DEPTH cycles, then 1.
//     -> Word loads from 0x000..0x1FC all return 0x00000000.
//  2. Store word 0x8765_43A1 @0x010; load byte signed @0x010, byte unsigned @0x010, half signed @0x012:
//     -> 0xFFFFFFA1, 0x000000A1, 0xFFFF8765.
//  3. Store byte 0x5A @0x013 over 0x8765_43A1; load word @0x010
//     -> 0x5A6543A1 (other lanes kept).
//  4. RD_LAT=3, four back-to-back loads @0x0,0x4,0x8,0xC holding 1,2,3,4:
//     -> rsp_valid on 4 consecutive cycles starting 3 cycles after the first accept, data 1,2,3,4.
//  5. Loads in flight, pull reset_n low mid-pipeline:
//     -> rsp_valid drops immediately, no stale response after release, and re-init runs.
//  6. MEM_ALIGN_CHK_EN: store half @0x021 then load word @0x022:
//     -> err pulses twice; memory unchanged; load returns 0.
//     Without macro: same store writes lanes 1:0 of word 0x020.

Source files
------------

// File: rtl/mem_datos_param.sv
// mem_datos_param: parametrised byte-addressed data memory for the MEM stage.
// Byte/half/word loads and stores with sign or zero extension on loads,
// a valid/ready request port, and a load pipeline of RD_LAT (1..4) cycles.
// After reset an init sweep clears every word before requests are accepted.
// Optional feature: define MEM_ALIGN_CHK_EN to detect misaligned accesses
// (misaligned stores are dropped, misaligned loads return 0, err pulses).
module mem_datos_param #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = $clog2(DEPTH) + 2,
  parameter int RD_LAT = 1
) (
  input  logic              reloj,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              err
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Byte-lane enable for a store of the given size at the given low address bits.
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001 << lane;
      SZ_HALF: m = lane[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Replicate right-justified store data onto every lane it could land on.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] d;
    case (size)
      SZ_BYTE: d = {4{wdata[7:0]}};
      SZ_HALF: d = {2{wdata[15:0]}};
      default: d = wdata;
    endcase
    return d;
  endfunction

  // Select the addressed lane(s) of a word and sign or zero extend to 32 bits.
  function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: r = {{24{~uns & b[7]}}, b};
      SZ_HALF: r = {{16{~uns & h[15]}}, h};
      default: r = word;
    endcase
    return r;
  endfunction

`ifdef MEM_ALIGN_CHK_EN
  // Half needs an even address, word (and reserved) needs a multiple of four.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic m;
    case (size)
      SZ_BYTE: m = 1'b0;
      SZ_HALF: m = lane[0];
      default: m = (lane != 2'b00);
    endcase
    return m;
  endfunction
`endif

  state_t           state_r, state_nxt;
  logic [IDX_W-1:0] init_idx_r, init_idx_nxt;
  logic             ready_r;

  logic [31:0]      mem_r [DEPTH];

  logic             accept_s;
  logic             st_fire_s;
  logic             ld_fire_s;
  logic             mis_s;
  logic [IDX_W-1:0] word_idx_s;
  logic [1:0]       lane_s;
  logic [3:0]       wmask_s;
  logic [31:0]      wlanes_s;
  logic [31:0]      rd_word_s;
  logic [31:0]      wr_word_s;
  logic [31:0]      ld_data_s;

  logic [RD_LAT-1:0] pipe_vld_r;
  logic [31:0]       pipe_data_r [RD_LAT];
  logic [RD_LAT-1:0] vld_nxt;
  logic [31:0]       data_nxt [RD_LAT];

  assign accept_s   = req_valid & ready_r;
  assign st_fire_s  = accept_s & req_we;
  assign ld_fire_s  = accept_s & ~req_we;
  assign word_idx_s = req_addr[ADDR_W-1:2];
  assign lane_s     = req_addr[1:0];
  assign wmask_s    = lane_mask(req_size, lane_s);
  assign wlanes_s   = lane_data(req_size, req_wdata);
  assign rd_word_s  = mem_r[word_idx_s];

  // Init sweep sequencing: count through every word once, then run until reset.
  always_comb begin
    state_nxt    = state_r;
    init_idx_nxt = init_idx_r;
    case (state_r)
      ST_INIT: begin
        if (init_idx_r == IDX_W'(DEPTH - 1)) begin
          state_nxt    = ST_RUN;
          init_idx_nxt = '0;
        end else begin
          state_nxt    = ST_INIT;
          init_idx_nxt = init_idx_r + IDX_W'(1);
        end
      end
      ST_RUN: begin
        state_nxt    = ST_RUN;
        init_idx_nxt = init_idx_r;
      end
      default: begin
        state_nxt    = ST_INIT;
        init_idx_nxt = '0;
      end
    endcase
  end

  // State, init index and the registered ready flag.
  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_INIT;
      init_idx_r <= '0;
      ready_r    <= 1'b0;
    end else begin
      state_r    <= state_nxt;
      init_idx_r <= init_idx_nxt;
      ready_r    <= (state_nxt == ST_RUN);
    end
  end

  assign req_ready = ready_r;

  // Merge store lanes into the current word; untouched lanes keep their bytes.
  always_comb begin
    wr_word_s = rd_word_s;
    for (int l = 0; l < 4; l++) begin
      if (wmask_s[l]) begin
        wr_word_s[8*l +: 8] = wlanes_s[8*l +: 8];
      end else begin
        wr_word_s[8*l +: 8] = rd_word_s[8*l +: 8];
      end
    end
  end

  // Storage array: zero-fill during init, accepted (aligned) stores in run.
  always_ff @(posedge reloj) begin
    if (state_r == ST_INIT) begin
      mem_r[init_idx_r] <= 32'h0000_0000;
    end else if (st_fire_s && !mis_s) begin
      mem_r[word_idx_s] <= wr_word_s;
    end
  end

  // Load result at accept: misaligned loads (when checked) yield zero.
  always_comb begin
    if (mis_s) begin
      ld_data_s = 32'h0000_0000;
    end else begin
      ld_data_s = extend_load(rd_word_s, req_size, lane_s, req_unsigned);
    end
  end

  // Next contents of each pipeline stage: stage 0 takes the new load.
  always_comb begin
    vld_nxt = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      data_nxt[i] = 32'h0000_0000;
    end
    vld_nxt[0]  = ld_fire_s;
    data_nxt[0] = ld_data_s;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_nxt[i]  = pipe_vld_r[i-1];
      data_nxt[i] = pipe_data_r[i-1];
    end
  end

  // Load pipeline; data stages only move on valid so the last stage holds rsp_rdata.
  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) begin
      pipe_vld_r <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipe_data_r[i] <= 32'h0000_0000;
      end
    end else begin
      pipe_vld_r <= vld_nxt;
      for (int i = 0; i < RD_LAT; i++) begin
        if (vld_nxt[i]) begin
          pipe_data_r[i] <= data_nxt[i];
        end
      end
    end
  end

  assign rsp_valid = pipe_vld_r[RD_LAT-1];
  assign rsp_rdata = pipe_data_r[RD_LAT-1];

`ifdef MEM_ALIGN_CHK_EN
  logic [RD_LAT-1:0] pipe_mis_r;
  logic [RD_LAT-1:0] mis_nxt;
  logic              err_r;

  assign mis_s = misaligned(req_size, lane_s);

  // Misaligned flag travels alongside its load.
  always_comb begin
    mis_nxt    = '0;
    mis_nxt[0] = ld_fire_s & mis_s;
    for (int i = 1; i < RD_LAT; i++) begin
      mis_nxt[i] = pipe_mis_r[i-1];
    end
  end

  // err: store pulse the cycle after accept, load pulse alongside rsp_valid.
  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) begin
      pipe_mis_r <= '0;
      err_r      <= 1'b0;
    end else begin
      pipe_mis_r <= mis_nxt;
      err_r      <= (st_fire_s & mis_s) | (vld_nxt[RD_LAT-1] & mis_nxt[RD_LAT-1]);
    end
  end

  assign err = err_r;
`else
  assign mis_s = 1'b0;
  assign err   = 1'b0;
`endif

endmodule
